// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: RS232 transmitter fed by a write FIFO; bit period, data width,
// parity and stop bits are parameters. Queued words go out back-to-back.
module uart_tx_fifo #(
    parameter int CLOCK_BIT  = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [DATA_BITS-1:0]             writedata,
    input  logic                             write,
    output logic                             full,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  level,
    output logic                             overflow,
    output logic                             active,
    output logic                             done,
    output logic                             tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam logic [15:0] BIT_LAST   = 16'(CLOCK_BIT - 1);
    localparam logic [15:0] STOP_LAST  = 16'(CLOCK_BIT * STOP_BITS - 1);
    localparam logic [3:0]  DATA_LAST  = 4'(DATA_BITS - 1);
    localparam bit          USE_PARITY = (PARITY == 1) || (PARITY == 2);

    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        count;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;

    state_t               state, state_n;
    logic [15:0]          cnt, cnt_n;
    logic [3:0]           bit_idx, bit_idx_n;
    logic [DATA_BITS-1:0] shift;
    logic                 shift_en, parity_bit, finish, finish_r, tx_c;

    assign full  = (count == LW'(FIFO_DEPTH));
    assign level = count;
    assign push  = write && (!full || pop);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= writedata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + LW'(1);
            else if (pop && !push) count <= count - LW'(1);
            overflow <= write && !push;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 16'd1;
        bit_idx_n = bit_idx;
        pop       = 1'b0;
        shift_en  = 1'b0;
        finish    = 1'b0;
        tx_c      = 1'b1;
        case (state)
            ST_IDLE: begin
                cnt_n = '0;
                if (count != '0) begin
                    pop     = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                tx_c = 1'b0;
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_c = shift[0];
                if (cnt == BIT_LAST) begin
                    cnt_n    = '0;
                    shift_en = 1'b1;
                    if (bit_idx == DATA_LAST) state_n = USE_PARITY ? ST_PARITY : ST_STOP;
                    else                      bit_idx_n = bit_idx + 4'd1;
                end
            end
            ST_PARITY: begin
                tx_c = parity_bit;
                if (cnt == BIT_LAST) begin
                    cnt_n   = '0;
                    state_n = ST_STOP;
                end
            end
            ST_STOP: begin
                if (cnt == STOP_LAST) begin
                    cnt_n  = '0;
                    finish = 1'b1;
                    if (count != '0) begin
                        pop     = 1'b1;
                        state_n = ST_START;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Line outputs are registered from the state, so the pin trails the state
    // by one cycle; done is delayed twice to rise with the next start bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            parity_bit <= 1'b0;
            finish_r   <= 1'b0;
            tx         <= 1'b1;
            active     <= 1'b0;
            done       <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            if (pop) begin
                shift      <= head;
                parity_bit <= (PARITY == 1) ? ~^head : ^head;
            end else if (shift_en) begin
                shift <= shift >> 1;
            end
            finish_r <= finish;
            done     <= finish_r;
            tx       <= tx_c;
            active   <= (state != ST_IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: four transmitters (8N1, 8E1 with a 4-deep FIFO, 8O1, 7E2) at
// four clocks per bit, checked cycle by cycle against a bit-level frame model.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
    localparam int CB = 4;

    logic       clk, rst;
    logic [3:0] wr, tx_v, act_v, done_v, full_v, ovf_v;
    logic [7:0] wd0, wd1, wd2;
    logic [6:0] wd3;
    logic [3:0] lvl0, lvl2, lvl3;
    logic [2:0] lvl1;
    logic [7:0] acc [6];
    int         tests, failed;

    uart_tx_fifo #(.CLOCK_BIT(CB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) dut0 (
        .clock(clk), .reset(rst), .writedata(wd0), .write(wr[0]), .full(full_v[0]), .level(lvl0),
        .overflow(ovf_v[0]), .active(act_v[0]), .done(done_v[0]), .tx(tx_v[0]));
    uart_tx_fifo #(.CLOCK_BIT(CB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) dut1 (
        .clock(clk), .reset(rst), .writedata(wd1), .write(wr[1]), .full(full_v[1]), .level(lvl1),
        .overflow(ovf_v[1]), .active(act_v[1]), .done(done_v[1]), .tx(tx_v[1]));
    uart_tx_fifo #(.CLOCK_BIT(CB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(8)) dut2 (
        .clock(clk), .reset(rst), .writedata(wd2), .write(wr[2]), .full(full_v[2]), .level(lvl2),
        .overflow(ovf_v[2]), .active(act_v[2]), .done(done_v[2]), .tx(tx_v[2]));
    uart_tx_fifo #(.CLOCK_BIT(CB), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) dut3 (
        .clock(clk), .reset(rst), .writedata(wd3), .write(wr[3]), .full(full_v[3]), .level(lvl3),
        .overflow(ovf_v[3]), .active(act_v[3]), .done(done_v[3]), .tx(tx_v[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic int db_of(input int i);
        return (i == 3) ? 7 : 8;
    endfunction

    function automatic int par_of(input int i);
        case (i)
            1:       return 2;
            2:       return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

    function automatic int sb_of(input int i);
        return (i == 3) ? 2 : 1;
    endfunction

    function automatic int frame_len(input int i);
        return (1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * CB;
    endfunction

    // Bit at serial position pos: start, data LSB first, optional parity, stop bits.
    function automatic logic exp_bit(input int i, input logic [7:0] w, input int pos);
        int ones;
        ones = 0;
        for (int b = 0; b < db_of(i); b++) ones += int'(w[b]);
        if (pos == 0) return 1'b0;
        if (pos <= db_of(i)) return w[pos-1];
        if (par_of(i) != 0 && pos == db_of(i) + 1)
            return (par_of(i) == 1) ? (ones % 2 == 0) : (ones % 2 == 1);
        return 1'b1;
    endfunction

    function automatic logic [3:0] lvl_of(input int i);
        case (i)
            0:       return lvl0;
            1:       return {1'b0, lvl1};
            2:       return lvl2;
            default: return lvl3;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int i, input logic [7:0] w);
        case (i)
            0:       wd0 = w;
            1:       wd1 = w;
            2:       wd2 = w;
            default: wd3 = w[6:0];
        endcase
        wr[i] = 1'b1;
    endtask

    // Waits for the start bit, then checks every cycle of the frame; returns
    // one cycle after the last stop cycle, where done must be high.
    task automatic check_frame(input int i, input logic [7:0] w, input int max_wait, output int waited);
        int   len, bad_tx, bad_act, bad_done, first_k;
        logic e, got;
        waited = 0;
        while (tx_v[i] !== 1'b0 && waited < max_wait) begin
            tick();
            waited++;
        end
        tests++;
        if (tx_v[i] !== 1'b0) begin
            failed++;
            $display("FAIL frame_start_%0d: tx=%b after %0d cycles, required 0", i, tx_v[i], waited);
            return;
        end
        len = frame_len(i);
        bad_tx = 0; bad_act = 0; bad_done = 0; first_k = -1; e = 1'b0; got = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (tx_v[i] !== exp_bit(i, w, k / CB)) begin
                if (bad_tx == 0) begin
                    first_k = k;
                    got = tx_v[i];
                    e = exp_bit(i, w, k / CB);
                end
                bad_tx++;
            end
            if (act_v[i] !== 1'b1) bad_act++;
            if (k > 0 && done_v[i] !== 1'b0) bad_done++;
            tick();
        end
        tests += 4;
        if (bad_tx != 0) begin
            failed++;
            $display("FAIL frame_tx_%0d word %h: %0d cycles wrong, first at cycle %0d tx=%b required %b",
                     i, w, bad_tx, first_k, got, e);
        end
        if (bad_act != 0) begin
            failed++;
            $display("FAIL frame_active_%0d: active low on %0d cycles, required 1 throughout", i, bad_act);
        end
        if (bad_done != 0) begin
            failed++;
            $display("FAIL frame_done_early_%0d: done high on %0d cycles, required 0", i, bad_done);
        end
        if (done_v[i] !== 1'b1) begin
            failed++;
            $display("FAIL frame_done_%0d: done=%b at cycle %0d, required 1", i, done_v[i], len);
        end
    endtask

    task automatic wait_done(input int i, input int max_cycles);
        int n;
        n = 0;
        while (done_v[i] !== 1'b1 && n < max_cycles) begin
            tick();
            n++;
        end
        tests++;
        if (done_v[i] !== 1'b1) begin
            failed++;
            $display("FAIL wait_done_%0d: done=%b after %0d cycles, required 1", i, done_v[i], n);
        end
    endtask

    task automatic test_reset();
        #2;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if ({tx_v[i], act_v[i], done_v[i], ovf_v[i], full_v[i]} !== 5'b10000 || lvl_of(i) !== 4'd0) begin
                failed++;
                $display("FAIL reset_%0d: tx,active,done,overflow,full=%b level=%0d, required 10000 level=0",
                         i, {tx_v[i], act_v[i], done_v[i], ovf_v[i], full_v[i]}, lvl_of(i));
            end
        end
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (tx_v[i] !== 1'b1 || act_v[i] !== 1'b0 || lvl_of(i) !== 4'd0) begin
                failed++;
                $display("FAIL idle_after_reset_%0d: tx=%b active=%b level=%0d, required 1 0 0",
                         i, tx_v[i], act_v[i], lvl_of(i));
            end
        end
    endtask

    task automatic test_8n1_frame();
        int waited;
        put(0, 8'hA5);
        tick();
        wr[0] = 1'b0;
        tests++;
        if (lvl_of(0) !== 4'd1 || tx_v[0] !== 1'b1) begin
            failed++;
            $display("FAIL latency_e0: level=%0d tx=%b, required 1 1", lvl_of(0), tx_v[0]);
        end
        tick();
        tests++;
        if (lvl_of(0) !== 4'd0 || tx_v[0] !== 1'b1) begin
            failed++;
            $display("FAIL latency_e1: level=%0d tx=%b, required 0 1", lvl_of(0), tx_v[0]);
        end
        tick();
        tests++;
        if (tx_v[0] !== 1'b0 || act_v[0] !== 1'b1) begin
            failed++;
            $display("FAIL latency_e2: tx=%b active=%b, required 0 1", tx_v[0], act_v[0]);
        end
        check_frame(0, 8'hA5, 0, waited);
        tests++;
        if (act_v[0] !== 1'b0 || tx_v[0] !== 1'b1) begin
            failed++;
            $display("FAIL active_end: active=%b tx=%b at cycle 40, required 0 1", act_v[0], tx_v[0]);
        end
        tick();
        tests++;
        if (done_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL done_once: done=%b at cycle 41, required 0", done_v[0]);
        end
    endtask

    task automatic test_parity();
        logic [7:0] w;
        int         waited;
        for (int i = 1; i < 4; i++) begin
            for (int r = 0; r < 2; r++) begin
                if (r == 0) w = (i == 3) ? 8'h55 : 8'h07;
                else        w = 8'($urandom_range(0, 255));
                put(i, w);
                tick();
                wr[i] = 1'b0;
                check_frame(i, w, 4, waited);
                tests++;
                if (waited != 2) begin
                    failed++;
                    $display("FAIL start_latency_%0d: tx fell %0d edges after write edge, required 2", i, waited);
                end
                tick();
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ws [3];
        int         waited;
        put(0, 8'($urandom));
        tick();
        wr[0] = 1'b0;
        tick();
        tick();
        tests++;
        if (tx_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL b2b_lead_start: tx=%b, required 0", tx_v[0]);
        end
        for (int k = 0; k < 3; k++) begin
            ws[k] = 8'($urandom);
            put(0, ws[k]);
            tick();
            tests++;
            if (lvl_of(0) !== 4'(k + 1)) begin
                failed++;
                $display("FAIL b2b_level_%0d: level=%0d, required %0d", k, lvl_of(0), k + 1);
            end
        end
        wr[0] = 1'b0;
        wait_done(0, 60);
        tests++;
        if (lvl_of(0) !== 4'd2 || tx_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL b2b_first_pop: level=%0d tx=%b, required 2 0", lvl_of(0), tx_v[0]);
        end
        for (int k = 0; k < 3; k++) begin
            check_frame(0, ws[k], 0, waited);
            tests++;
            if (lvl_of(0) !== ((k < 2) ? 4'(1 - k) : 4'd0)) begin
                failed++;
                $display("FAIL b2b_level_after_%0d: level=%0d, required %0d", k, lvl_of(0), (k < 2) ? 1 - k : 0);
            end
        end
        tick();
        tests++;
        if (tx_v[0] !== 1'b1 || act_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL b2b_idle: tx=%b active=%b, required 1 0", tx_v[0], act_v[0]);
        end
    endtask

    // Leaves dut1 full with its first frame's start bit 7 cycles in the past.
    task automatic test_overflow();
        int exp_lvl;
        put(1, 8'($urandom));
        tick();
        wr[1] = 1'b0;
        tick();
        tick();
        tests++;
        if (tx_v[1] !== 1'b0) begin
            failed++;
            $display("FAIL ovf_frame_start: tx=%b, required 0", tx_v[1]);
        end
        for (int k = 0; k < 6; k++) begin
            acc[k] = 8'($urandom);
            put(1, acc[k]);
            tick();
            exp_lvl = (k < 4) ? k + 1 : 4;
            tests++;
            if (lvl_of(1) !== 4'(exp_lvl) || full_v[1] !== (exp_lvl == 4) || ovf_v[1] !== (k >= 4)) begin
                failed++;
                $display("FAIL ovf_write_%0d: level=%0d full=%b overflow=%b, required %0d %b %b",
                         k, lvl_of(1), full_v[1], ovf_v[1], exp_lvl, exp_lvl == 4, k >= 4);
            end
        end
        wr[1] = 1'b0;
        tick();
        tests++;
        if (ovf_v[1] !== 1'b0 || lvl_of(1) !== 4'd4) begin
            failed++;
            $display("FAIL ovf_clear: overflow=%b level=%0d, required 0 4", ovf_v[1], lvl_of(1));
        end
    endtask

    // The frame's stop state ends on the edge 43 cycles after the start bit
    // showed; that edge pops the head, so a write there meets a full FIFO.
    task automatic test_full_pop();
        logic [7:0] extra;
        logic [7:0] order [5];
        int         waited;
        repeat (35) tick();
        extra = 8'($urandom);
        put(1, extra);
        tick();
        wr[1] = 1'b0;
        tests++;
        if (lvl_of(1) !== 4'd4 || full_v[1] !== 1'b1 || ovf_v[1] !== 1'b0) begin
            failed++;
            $display("FAIL full_pop_write: level=%0d full=%b overflow=%b, required 4 1 0",
                     lvl_of(1), full_v[1], ovf_v[1]);
        end
        tick();
        tests++;
        if (done_v[1] !== 1'b1 || tx_v[1] !== 1'b0) begin
            failed++;
            $display("FAIL full_pop_handover: done=%b tx=%b, required 1 0", done_v[1], tx_v[1]);
        end
        order[0] = acc[0]; order[1] = acc[1]; order[2] = acc[2]; order[3] = acc[3]; order[4] = extra;
        for (int k = 0; k < 5; k++) begin
            check_frame(1, order[k], 0, waited);
        end
        tests++;
        if (lvl_of(1) !== 4'd0 || full_v[1] !== 1'b0) begin
            failed++;
            $display("FAIL full_pop_drained: level=%0d full=%b, required 0 0", lvl_of(1), full_v[1]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int         bad;
        int         waited;
        logic [7:0] w;
        put(0, 8'($urandom));
        tick();
        put(0, 8'($urandom));
        tick();
        put(0, 8'($urandom));
        tick();
        wr[0] = 1'b0;
        repeat (8) tick();
        tests++;
        if (lvl_of(0) !== 4'd2 || act_v[0] !== 1'b1) begin
            failed++;
            $display("FAIL pre_reset: level=%0d active=%b, required 2 1", lvl_of(0), act_v[0]);
        end
        #3 rst = 1'b1;
        #1;
        tests++;
        if (tx_v[0] !== 1'b1 || act_v[0] !== 1'b0 || lvl_of(0) !== 4'd0 || done_v[0] !== 1'b0 || full_v[0] !== 1'b0) begin
            failed++;
            $display("FAIL async_reset: tx=%b active=%b level=%0d done=%b full=%b, required 1 0 0 0 0",
                     tx_v[0], act_v[0], lvl_of(0), done_v[0], full_v[0]);
        end
        tick();
        #2 rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (tx_v[0] !== 1'b1 || act_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0 || lvl_of(0) !== 4'd0) begin
            failed++;
            $display("FAIL post_reset_quiet: %0d cycles not idle, level=%0d, required 0 and 0", bad, lvl_of(0));
        end
        w = 8'($urandom);
        put(0, w);
        tick();
        wr[0] = 1'b0;
        check_frame(0, w, 4, waited);
    endtask

    initial begin
        tests = 0;
        failed = 0;
        rst = 1'b0;
        wr = '0;
        wd0 = '0;
        wd1 = '0;
        wd2 = '0;
        wd3 = '0;
        #1 rst = 1'b1;
        test_reset();
        test_8n1_frame();
        test_parity();
        test_back_to_back();
        test_overflow();
        test_full_pop();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
